// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared defaults and types for the multi-port register file
package rf_pkg;
  localparam int RF_DATA_W   = 32;
  localparam int RF_NUM_REGS = 32;
  localparam int RF_ADDR_W   = $clog2(RF_NUM_REGS);
  localparam int RF_ZERO_REG = 0;

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;
endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - busy scoreboard with claim/clear/flush priority and per-port lookup
// Lookup is write-first when REG_FILE_MP_BYPASS_EN is defined, read-first otherwise.
import rf_pkg::*;

module rf_scoreboard #(
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic                     claim_en,
  input  logic [ADDR_W-1:0]        claim_addr,
  input  logic                     flush,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        lookup_busy
);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;

  // Claim is applied after the write-clear so a newer producer keeps the register busy.
  always_comb begin
    busy_next = busy;
    if (flush) begin
      busy_next = '0;
    end else begin
      if (wr_en)    busy_next[wr_addr]    = 1'b0;
      if (claim_en) busy_next[claim_addr] = 1'b1;
    end
    busy_next[RF_ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_lookup
    logic [ADDR_W-1:0] addr;
    assign addr = rd_addr[p*ADDR_W +: ADDR_W];
`ifdef REG_FILE_MP_BYPASS_EN
    assign lookup_busy[p] = (wr_en && addr == wr_addr) ? busy_next[addr] : busy[addr];
`else
    assign lookup_busy[p] = busy[addr];
`endif
  end

endmodule

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-port register file with registered reads and busy scoreboard
// REG_FILE_MP_BYPASS_EN selects write-first same-cycle reads; default is read-first.
import rf_pkg::*;

module reg_file_mp #(
  parameter int DATA_W   = RF_DATA_W,
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     claim_en,
  input  logic [ADDR_W-1:0]        claim_addr,
  input  logic                     flush
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(RF_ZERO_REG);

  logic [DATA_W-1:0] mem [NUM_REGS];
  logic [NUM_RD-1:0] lookup_busy;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (wr_en && wr_addr != ZERO_ADDR) begin
      mem[wr_addr] <= wr_data;
    end
  end

  rf_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD)
  ) u_scoreboard (
    .clk         (clk),
    .reset_n     (reset_n),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .claim_en    (claim_en),
    .claim_addr  (claim_addr),
    .flush       (flush),
    .rd_addr     (rd_addr),
    .lookup_busy (lookup_busy)
  );

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              busy_q;

    assign addr = rd_addr[p*ADDR_W +: ADDR_W];

`ifdef REG_FILE_MP_BYPASS_EN
    assign rd_word = (addr == ZERO_ADDR)           ? '0      :
                     (wr_en && addr == wr_addr)    ? wr_data : mem[addr];
`else
    assign rd_word = (addr == ZERO_ADDR) ? '0 : mem[addr];
`endif

    // Data and busy hold their last value while the port is idle.
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        data_q  <= '0;
        valid_q <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        valid_q <= rd_en[p];
        if (rd_en[p]) begin
          data_q <= rd_word;
          busy_q <= lookup_busy[p];
        end
      end
    end

    assign rd_data[p*DATA_W +: DATA_W] = data_q;
    assign rd_valid[p] = valid_q;
    assign rd_busy[p]  = busy_q;
  end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-port register file for the pipeline's decode/writeback stages. It provides NUM_RD registered read ports and one write port, and register 0 is hardwired to zero. A per-register busy scoreboard lets decode detect RAW hazards against in-flight producers. It replaces the fixed 2-read/32x32 register file.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- NUM_REGS, 32, number of architectural registers (power of two, ≥2)
- ADDR_W, $clog2(NUM_REGS), register address width
- NUM_RD, 2, number of read ports (1..4)

Ports (clock and reset: one clock; reset is synchronous and active-low):
- clk  in  1  sole clock, all state updates on rising edge
- reset_n  in  1  synchronous active-low reset
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write register index
- wr_data  in  DATA_W  write data
- rd_en  in  NUM_RD  per-port read request
- rd_addr  in  NUM_RD*ADDR_W  read indices, port p at [p*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  registered read data, port p at [p*DATA_W +: DATA_W]
- rd_valid  out  NUM_RD  rd_data of port p updated this cycle
- rd_busy  out  NUM_RD  register read on port p has a pending producer
- claim_en  in  1  mark claim_addr busy (instruction with destination issued)
- claim_addr  in  ADDR_W  register being claimed
- flush  in  1  clear all busy bits (pipeline flush)

## Operation
- Storage: NUM_REGS x DATA_W array plus a NUM_REGS-bit busy vector.
- Write: when wr_en=1 and wr_addr≠0, mem[wr_addr] <= wr_data and busy[wr_addr] <= 0. A write to register 0 is ignored.
- Claim: when claim_en=1 and claim_addr≠0, busy[claim_addr] <= 1. A claim of register 0 is ignored.
- Claim and write to the same address in the same cycle: the claim wins and busy stays 1, because a newer producer has issued. The data write still happens.
- Flush: busy <= 0 for all registers. A claim in the same cycle as flush is dropped. A write in the same cycle as flush is still performed.
- Read, per port p, when rd_en[p]=1:
  - Next cycle: rd_data[p] = mem[rd_addr[p]], rd_valid[p]=1, rd_busy[p]=busy[rd_addr[p]].
  - Register 0 always returns 0 with rd_busy=0.
- When rd_en[p]=0: rd_data[p] and rd_busy[p] hold their last value, and rd_valid[p]=0.
- All read ports are independent. Any number of ports may read the same address simultaneously.

## Timing
- Read latency is 1 cycle, from rd_en sampled at edge N to rd_data/rd_valid valid after edge N.
- Write takes effect at the edge where it is sampled. A read issued at any later edge sees the new value.
- A write and a read to the same address in the same cycle follow the Configuration rule.
- Reset (reset_n=0 at an edge) overrides everything, including a write, claim or read in the same cycle:
  - all mem entries become 0
  - busy becomes 0
  - rd_data becomes 0, rd_valid 0, rd_busy 0
- A reset taken mid-operation discards all in-flight claims. The first read after reset returns 0 for every register.
- No backpressure: every request completes in exactly one cycle.

## Configuration
- Macro: REG_FILE_MP_BYPASS_EN.
- Defined: a same-cycle read of wr_addr (≠0) while wr_en=1 returns wr_data (write-first). rd_busy reflects the post-write busy state, so it is 0 unless the same address is also claimed that cycle.
- Undefined: that read returns the old mem contents (read-first). rd_busy reflects the pre-write busy state. The consumer sees busy=1 and retries, so the stale data is never consumed.

## Structure
- Shared package rf_pkg:
  - defaults RF_DATA_W=32, RF_NUM_REGS=32, RF_ADDR_W
  - constant RF_ZERO_REG=0
  - typedef rf_addr_t
- Sub-module rf_scoreboard: the busy vector with claim/write-clear/flush priority and the per-port busy lookup (including the bypass variant). It is instantiated once.
- Read ports are generated with a generate loop over NUM_RD.

## Test plan
- Reset then read: reset_n=0 for 2 cycles, then read regs 0, 5 and 31 on both ports. Required: rd_data=0, rd_busy=0, rd_valid=1 one cycle after each rd_en.
- Write/read: write 0xDEADBEEF to r7, then read r7 on port 0 and r0 on port 1 next cycle. Required: port 0 = 0xDEADBEEF, port 1 = 0. Writing 0x1234 to r0 leaves r0 reading 0.
- Same-cycle bypass: with r9=0x11 stored, write 0x22 to r9 while reading r9. Required: 0x22 with REG_FILE_MP_BYPASS_EN, 0x11 without. In both builds the next read returns 0x22.
- Scoreboard:
  - Claim r3, then read r3. Required: rd_busy=1.
  - Write r3, then read. Required: rd_busy=0.
  - Claim and write r3 in the same cycle. Required: a subsequent read shows rd_busy=1 and the new data.
- Flush and reset priority:
  - Claim r4 and r5, then assert flush. Required: both read back busy=0.
  - Assert reset_n=0 in the same cycle as a write to r6 of 0xFF. Required: r6 reads 0.
- Parameter sweep: NUM_RD=4, NUM_REGS=16, DATA_W=64. Drive random concurrent reads, writes and claims against a reference model. Required: zero mismatches over 10k cycles.
